inst_mem_loader: RTL and testbench

Boot-time loader that sits directly upstream of the single-cycle CPU.
- Clears the instruction memory.
- Accepts a byte stream over a valid/ready handshake: 2-byte word-count header, then big-endian instruction words.
- Writes each assembled 32-bit word into the instruction memory through its write port.
- Asserts start_o to the CPU once the program is resident.
- Replaces simulation-only memory initialisation and file loading with synthesizable hardware.

---
 rtl/inst_loader_pkg.sv | 10 +
 rtl/inst_mem_loader_byte_packer.sv | 35 +++
 rtl/inst_mem_loader.sv | 114 +++++++++++
 tb/tb_inst_mem_loader.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared state encoding and sizing constants for the boot-time instruction loader
package inst_loader_pkg;

   typedef enum logic [2:0] {CLEAR, HDR, DATA, DONE, ERR} state_t;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int CNT_W          = 16;

endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// byte_packer: assembles big-endian bytes into 32-bit words and flags the byte that completes each word
module byte_packer
   import inst_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr,
   input  logic        shift,
   input  logic [7:0]  byte_data,
   output logic        word_done,
   output logic [31:0] word
);

   logic [23:0] shift_reg;
   logic [1:0]  cnt;

   // the completing byte is passed straight through so the parent can register the word on the same edge
   assign word_done = shift && cnt == 2'(BYTES_PER_WORD - 1);
   assign word      = {shift_reg, byte_data};

   // shift earlier bytes towards the MSB end and count bytes within the current word
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         shift_reg <= '0;
         cnt       <= '0;
      end else if (clr) begin
         shift_reg <= '0;
         cnt       <= '0;
      end else if (shift) begin
         shift_reg <= {shift_reg[15:0], byte_data};
         cnt       <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: clears instruction memory, loads a length-prefixed byte stream into it, then starts the CPU
module inst_mem_loader
   import inst_loader_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_data_i,
   output logic              byte_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              start_o,
   output logic              busy_o,
   output logic              err_o
);

   state_t           state;
   logic [CNT_W-1:0] clr_cnt;
   logic [CNT_W-1:0] idx;
   logic [CNT_W-1:0] n_words;
   logic [CNT_W-1:0] n_hdr;
   logic [7:0]       n_hi;
   logic             hdr_cnt;
   logic             take;
   logic             word_done;
   logic [31:0]      word;

   assign take  = byte_valid_i & byte_ready_o;
   assign n_hdr = {n_hi, byte_data_i};

   byte_packer u_packer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr       (state == HDR && take),
      .shift     (state == DATA && take),
      .byte_data (byte_data_i),
      .word_done (word_done),
      .word      (word)
   );

   // loader sequencing; every output is registered so the memory and CPU see glitch-free strobes
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= CLEAR;
         clr_cnt      <= '0;
         idx          <= '0;
         n_words      <= '0;
         n_hi         <= '0;
         hdr_cnt      <= 1'b0;
         byte_ready_o <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         start_o      <= 1'b0;
         busy_o       <= 1'b1;
         err_o        <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               if (clr_cnt == CNT_W'(DEPTH)) begin
                  state        <= HDR;
                  mem_we_o     <= 1'b0;
                  byte_ready_o <= 1'b1;
               end else begin
                  mem_we_o   <= 1'b1;
                  mem_addr_o <= clr_cnt[ADDR_W-1:0];
                  mem_data_o <= '0;
                  clr_cnt    <= clr_cnt + 1'b1;
               end
            end
            HDR: begin
               if (take) begin
                  if (hdr_cnt != 1'(HDR_BYTES - 1)) begin
                     n_hi    <= byte_data_i;
                     hdr_cnt <= 1'b1;
                  end else if (n_hdr == '0 || n_hdr > CNT_W'(DEPTH)) begin
                     state        <= ERR;
                     byte_ready_o <= 1'b0;
                     busy_o       <= 1'b0;
                     err_o        <= 1'b1;
                  end else begin
                     state   <= DATA;
                     n_words <= n_hdr;
                     idx     <= '0;
                  end
               end
            end
            DATA: begin
               if (mem_we_o && idx == n_words) begin
                  state        <= DONE;
                  mem_we_o     <= 1'b0;
                  byte_ready_o <= 1'b0;
                  busy_o       <= 1'b0;
                  start_o      <= 1'b1;
               end else begin
                  mem_we_o <= word_done;
                  if (word_done) begin
                     mem_addr_o <= idx[ADDR_W-1:0];
                     mem_data_o <= DATA_W'(word);
                     idx        <= idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: randomized self-checking bench for the instruction memory loader
module tb_inst_mem_loader;

   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              byte_valid_i = 1'b0;
   logic [7:0]        byte_data_i = '0;
   logic              byte_ready_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_data_o;
   logic              start_o;
   logic              busy_o;
   logic              err_o;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int stray_we = 0;
   bit stuck = 0;

   logic [ADDR_W+DATA_W-1:0] obs[$];
   logic [ADDR_W+DATA_W-1:0] exp_wr[$];
   int                       obs_cyc[$];
   int                       acc_q[$];
   logic [31:0]              words[$];

   inst_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .byte_valid_i (byte_valid_i),
      .byte_data_i  (byte_data_i),
      .byte_ready_o (byte_ready_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .start_o      (start_o),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   // edge counter used to time-stamp acceptances and writes
   always @(posedge clk_i) cyc <= cyc + 1;

   // program writes are the only writes that happen while the loader is ready for bytes
   always @(negedge clk_i) begin
      if (mem_we_o && byte_ready_o) begin
         obs.push_back({mem_addr_o, mem_data_o});
         obs_cyc.push_back(cyc);
      end
      if (mem_we_o && !busy_o) stray_we++;
   end

   task automatic send_byte(input logic [7:0] b, input bit gapped);
      int k;
      if (stuck) return;
      if (gapped) begin
         byte_valid_i = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk_i);
      end
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      k = 0;
      while (!byte_ready_o && k < 2000) begin
         @(negedge clk_i);
         k++;
      end
      if (!byte_ready_o) begin
         stuck = 1;
         compared++;
         mismatched++;
         $display("FAIL handshake_timeout: byte_ready_o=%0b required 1 within 2000 cycles", byte_ready_o);
         return;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      acc_q.push_back(cyc);
   endtask

   task automatic send_words(input bit gapped);
      logic [31:0] w;
      foreach (words[i]) begin
         w = words[i];
         for (int j = 3; j >= 0; j--) send_byte(w[8*j +: 8], gapped);
      end
   endtask

   task automatic load(input bit gapped);
      logic [15:0] n;
      n = 16'(words.size());
      send_byte(n[15:8], gapped);
      send_byte(n[7:0], gapped);
      send_words(gapped);
      byte_valid_i = 1'b0;
   endtask

   task automatic rand_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   task automatic make_exp();
      exp_wr.delete();
      foreach (words[i]) exp_wr.push_back({ADDR_W'(i), words[i]});
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      byte_valid_i = 1'b0;
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      obs.delete();
      obs_cyc.delete();
      acc_q.delete();
   endtask

   task automatic test_reset();
      logic [5+ADDR_W+DATA_W-1:0] got;
      #2 rst_i = 1'b0;
      #1 got = {byte_ready_o, mem_we_o, start_o, busy_o, err_o, mem_addr_o, mem_data_o};
      compared++;
      if (got !== {5'b00010, {(ADDR_W+DATA_W){1'b0}}}) begin
         mismatched++;
         $display("FAIL reset_values: got %h required %h", got, {5'b00010, {(ADDR_W+DATA_W){1'b0}}});
      end
   endtask

   task automatic test_clear_sweep();
      int bad;
      do_reset();
      bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk_i);
         if (mem_we_o !== 1'b1 || mem_addr_o !== ADDR_W'(i) || mem_data_o !== '0 || byte_ready_o !== 1'b0 || busy_o !== 1'b1) bad++;
      end
      compared++;
      if (bad !== 0) begin
         mismatched++;
         $display("FAIL clear_sweep: %0d bad cycles out of %0d, required 0", bad, DEPTH);
      end
      @(negedge clk_i);
      compared++;
      if ({mem_we_o, byte_ready_o, busy_o} !== 3'b011) begin
         mismatched++;
         $display("FAIL clear_exit: we,ready,busy=%b required 011", {mem_we_o, byte_ready_o, busy_o});
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      do_reset();
      words.delete();
      words.push_back(32'h20080005);
      words.push_back(32'h00094820);
      make_exp();
      load(0);
      compared++;
      if ({mem_we_o, mem_addr_o, mem_data_o, start_o} !== {1'b1, ADDR_W'(1), 32'h00094820, 1'b0}) begin
         mismatched++;
         $display("FAIL b2b_last_write: we=%b addr=%h data=%h start=%b required 1 01 00094820 0", mem_we_o, mem_addr_o, mem_data_o, start_o);
      end
      @(negedge clk_i);
      compared++;
      if ({start_o, busy_o, mem_we_o, byte_ready_o} !== 4'b1000) begin
         mismatched++;
         $display("FAIL b2b_start: start,busy,we,ready=%b required 1000", {start_o, busy_o, mem_we_o, byte_ready_o});
      end
      bad = 0;
      foreach (exp_wr[i]) if (i >= obs.size() || obs[i] !== exp_wr[i]) bad++;
      compared++;
      if (bad !== 0 || obs.size() !== exp_wr.size()) begin
         mismatched++;
         $display("FAIL b2b_writes: %0d writes with %0d wrong, required %0d writes with 0 wrong", obs.size(), bad, exp_wr.size());
      end
      compared++;
      if (obs_cyc.size() < 2 || acc_q.size() < 10 || obs_cyc[0] !== acc_q[5] || obs_cyc[1] !== acc_q[9]) begin
         mismatched++;
         $display("FAIL b2b_timing: write cycles %0d/%0d required %0d/%0d", obs_cyc.size() > 0 ? obs_cyc[0] : -1,
                  obs_cyc.size() > 1 ? obs_cyc[1] : -1, acc_q.size() > 5 ? acc_q[5] : -1, acc_q.size() > 9 ? acc_q[9] : -1);
      end
   endtask

   task automatic test_gapped();
      int bad;
      // first header byte is held valid through reset and the whole clear; it must be taken exactly once
      @(negedge clk_i);
      rst_i = 1'b0;
      byte_valid_i = 1'b1;
      byte_data_i = 8'h00;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      obs.delete();
      obs_cyc.delete();
      acc_q.delete();
      words.delete();
      words.push_back(32'h20080005);
      words.push_back(32'h00094820);
      make_exp();
      send_byte(8'h00, 0);
      send_byte(8'h02, 1);
      send_words(1);
      byte_valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      bad = 0;
      foreach (exp_wr[i]) if (i >= obs.size() || obs[i] !== exp_wr[i]) bad++;
      compared++;
      if (bad !== 0 || obs.size() !== exp_wr.size() || start_o !== 1'b1) begin
         mismatched++;
         $display("FAIL gapped_fixed: %0d writes %0d wrong start=%b, required %0d writes 0 wrong start=1", obs.size(), bad, start_o, exp_wr.size());
      end
      for (int r = 0; r < 2; r++) begin
         do_reset();
         rand_words($urandom_range(1, 6));
         make_exp();
         load(1);
         repeat (2) @(negedge clk_i);
         bad = 0;
         foreach (exp_wr[i]) if (i >= obs.size() || obs[i] !== exp_wr[i]) bad++;
         compared++;
         if (bad !== 0 || obs.size() !== exp_wr.size() || start_o !== 1'b1) begin
            mismatched++;
            $display("FAIL gapped_rand%0d: %0d writes %0d wrong start=%b, required %0d writes 0 wrong start=1", r, obs.size(), bad, start_o, exp_wr.size());
         end
      end
   endtask

   task automatic test_hdr_err();
      logic [15:0] hdrs[2];
      int bad;
      hdrs[0] = 16'h0000;
      hdrs[1] = 16'h0101;
      for (int h = 0; h < 2; h++) begin
         do_reset();
         send_byte(hdrs[h][15:8], 0);
         send_byte(hdrs[h][7:0], 0);
         bad = 0;
         for (int i = 0; i < 8; i++) begin
            byte_valid_i = 1'b1;
            byte_data_i = 8'($urandom);
            @(negedge clk_i);
            if (byte_ready_o !== 1'b0) bad++;
         end
         byte_valid_i = 1'b0;
         compared++;
         if ({err_o, start_o, busy_o} !== 3'b100) begin
            mismatched++;
            $display("FAIL hdr_err_flags_%h: err,start,busy=%b required 100", hdrs[h], {err_o, start_o, busy_o});
         end
         compared++;
         if (bad !== 0 || obs.size() !== 0) begin
            mismatched++;
            $display("FAIL hdr_err_quiet_%h: ready-high cycles=%0d writes=%0d required 0 and 0", hdrs[h], bad, obs.size());
         end
      end
   endtask

   task automatic test_max_words();
      int bad;
      do_reset();
      rand_words(DEPTH);
      make_exp();
      load(0);
      @(negedge clk_i);
      bad = 0;
      foreach (exp_wr[i]) if (i >= obs.size() || obs[i] !== exp_wr[i]) bad++;
      compared++;
      if (bad !== 0 || obs.size() !== DEPTH || start_o !== 1'b1 || err_o !== 1'b0) begin
         mismatched++;
         $display("FAIL max_words: %0d writes %0d wrong start=%b err=%b, required %0d writes 0 wrong start=1 err=0", obs.size(), bad, start_o, err_o, DEPTH);
      end
   endtask

   task automatic test_reset_mid_data();
      logic [5+ADDR_W+DATA_W-1:0] got;
      logic [31:0] w;
      int bad;
      do_reset();
      rand_words(3);
      send_byte(8'h00, 0);
      send_byte(8'h03, 0);
      for (int b = 0; b < 6; b++) begin
         w = words[b / 4];
         send_byte(w[8*(3 - b % 4) +: 8], 0);
      end
      compared++;
      if (obs.size() !== 1) begin
         mismatched++;
         $display("FAIL mid_pre_writes: %0d writes before reset, required 1", obs.size());
      end
      #2 rst_i = 1'b0;
      byte_valid_i = 1'b0;
      #1 got = {byte_ready_o, mem_we_o, start_o, busy_o, err_o, mem_addr_o, mem_data_o};
      compared++;
      if (got !== {5'b00010, {(ADDR_W+DATA_W){1'b0}}}) begin
         mismatched++;
         $display("FAIL mid_async_reset: got %h required %h", got, {5'b00010, {(ADDR_W+DATA_W){1'b0}}});
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      obs.delete();
      obs_cyc.delete();
      acc_q.delete();
      rand_words(3);
      make_exp();
      load(0);
      repeat (2) @(negedge clk_i);
      bad = 0;
      foreach (exp_wr[i]) if (i >= obs.size() || obs[i] !== exp_wr[i]) bad++;
      compared++;
      if (bad !== 0 || obs.size() !== 3 || start_o !== 1'b1) begin
         mismatched++;
         $display("FAIL mid_reload: %0d writes %0d wrong start=%b, required 3 writes 0 wrong start=1", obs.size(), bad, start_o);
      end
   endtask

   task automatic test_post_done();
      int bad;
      do_reset();
      rand_words(1);
      make_exp();
      load(1);
      repeat (2) @(negedge clk_i);
      compared++;
      if (obs.size() !== 1 || (obs.size() > 0 && obs[0] !== exp_wr[0])) begin
         mismatched++;
         $display("FAIL one_word: %0d writes first=%h, required 1 write %h", obs.size(), obs.size() > 0 ? obs[0] : '0, exp_wr[0]);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         byte_valid_i = 1'b1;
         byte_data_i = 8'($urandom);
         @(negedge clk_i);
         if ({byte_ready_o, mem_we_o, start_o, busy_o} !== 4'b0010) bad++;
      end
      byte_valid_i = 1'b0;
      compared++;
      if (bad !== 0 || obs.size() !== 1) begin
         mismatched++;
         $display("FAIL post_done: %0d bad cycles, %0d writes, required 0 bad and 1 write", bad, obs.size());
      end
      #2 rst_i = 1'b0;
      #1 compared++;
      if (start_o !== 1'b0) begin
         mismatched++;
         $display("FAIL start_async_fall: start_o=%b required 0", start_o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   initial begin
      test_reset();
      test_clear_sweep();
      test_back_to_back();
      test_gapped();
      test_hdr_err();
      test_max_words();
      test_reset_mid_data();
      test_post_done();
      compared++;
      if (stray_we !== 0) begin
         mismatched++;
         $display("FAIL stray_writes: %0d writes while idle, required 0", stray_we);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
